// File: rtl/cache_pkg.sv
// Package: cache_pkg
// Purpose: Shared types and defaults for the cache miss/write-back sequencer.
//   state_t      : sequencer states {IDLE, WB, RD, DONE}
//   ADDR_W_DEF   : default RAM/cache address width
//   DATA_W_DEF   : default block width
//   READ_LAT_MAX : largest RAM read latency the 3-bit latency counter can cover
//   LAT_CNT_W    : width of the latency counter
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 5;
    localparam int READ_LAT_MAX = 7;
    localparam int LAT_CNT_W    = 3;

endpackage

// File: rtl/sat_counter.sv
// Module: sat_counter
// Purpose: Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clock  in   1  rising-edge clock
//   reset  in   1  asynchronous active-high reset, clears the count
//   inc    in   1  add one this cycle (ignored once saturated)
//   clear  in   1  synchronous clear, wins over inc
//   count  out  W  current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Module: cache_mem_ctrl
// Purpose: Miss/write-back sequencer between the 2-way set-associative cache
//   and the single-port block RAM. One request per miss: an optional dirty
//   victim write-back (one cycle), then a block refill that waits READ_LAT
//   RAM clocks and returns the block with a one-cycle ack pulse.
//
// Handshake: the cache raises req and holds it, together with miss_addr,
//   wb_needed, wb_addr and wb_block, until ack. Those inputs are sampled only
//   on the clock edge that leaves IDLE; later changes are ignored. ack is a
//   single-cycle pulse during which refill_block is valid; refill_block then
//   holds until the next ack. req still high in DONE is not a new request;
//   the next one is taken in IDLE at the earliest.
//
// Configuration macro: CACHE_CTRL_STATS_EN adds the miss_cnt / wb_cnt
//   saturating statistics outputs (width STAT_W). Undefined: no counter
//   ports and no counter logic.
//
// Ports:
//   clock        in   1       rising-edge clock
//   reset        in   1       asynchronous active-high reset
//   req          in   1       miss service request, held until ack
//   miss_addr    in   ADDR_W  block address to refill
//   wb_needed    in   1       victim is dirty, write back first
//   wb_addr      in   ADDR_W  victim block address
//   wb_block     in   DATA_W  victim data
//   ack          out  1       one-cycle pulse, refill_block valid
//   refill_block out  DATA_W  block read from RAM, held until next ack
//   busy         out  1       high in every state except IDLE
//   mem_addr     out  ADDR_W  RAM address (0 in IDLE)
//   mem_wdata    out  DATA_W  RAM write data (keeps last value outside WB)
//   mem_wren     out  1       RAM write enable (WB only)
//   mem_rdata    in   DATA_W  RAM read data
//   state_dbg    out  2       current sequencer state, for observation
//   miss_cnt     out  STAT_W  accepted requests (CACHE_CTRL_STATS_EN only)
//   wb_cnt       out  STAT_W  write-backs started (CACHE_CTRL_STATS_EN only)
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    // Legal range 1..READ_LAT_MAX; the latency counter is LAT_CNT_W bits.
    parameter int READ_LAT = 2
`ifdef CACHE_CTRL_STATS_EN
    ,
    parameter int STAT_W   = 8
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              wb_needed,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_block,
    output logic              ack,
    output logic [DATA_W-1:0] refill_block,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_t            state_dbg
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] miss_cnt,
    output logic [STAT_W-1:0] wb_cnt
`endif
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LAT);

    state_t              state;
    logic [ADDR_W-1:0]   miss_addr_q;
    logic [LAT_CNT_W-1:0] lat_cnt;

    assign state_dbg = state;

    // All outputs are registered here. The write-back address/data go
    // straight into mem_addr/mem_wdata on the accepting edge, so only the
    // refill address has to be held for later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ack          <= 1'b0;
            busy         <= 1'b0;
            mem_wren     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            refill_block <= '0;
            miss_addr_q  <= '0;
            lat_cnt      <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        miss_addr_q <= miss_addr;
                        busy        <= 1'b1;
                        if (wb_needed) begin
                            state     <= WB;
                            mem_wren  <= 1'b1;
                            mem_addr  <= wb_addr;
                            mem_wdata <= wb_block;
                        end else begin
                            state    <= RD;
                            mem_addr <= miss_addr;
                            lat_cnt  <= LAT_CNT_W'(1);
                        end
                    end
                end
                WB: begin
                    // The write lands on this edge, so a refill of the same
                    // address afterwards reads the just-written block.
                    state    <= RD;
                    mem_wren <= 1'b0;
                    mem_addr <= miss_addr_q;
                    lat_cnt  <= LAT_CNT_W'(1);
                end
                RD: begin
                    if (lat_cnt == LAT_LAST) begin
                        state        <= DONE;
                        refill_block <= mem_rdata;
                        ack          <= 1'b1;
                        lat_cnt      <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_CNT_W'(1);
                    end
                end
                DONE: begin
                    // req is deliberately not looked at here.
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_addr <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic miss_inc;
    logic wb_inc;

    assign miss_inc = (state == IDLE) && req;
    assign wb_inc   = miss_inc && wb_needed;

    sat_counter #(.W(STAT_W)) u_miss_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (miss_inc),
        .clear (1'b0),
        .count (miss_cnt)
    );

    sat_counter #(.W(STAT_W)) u_wb_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (wb_inc),
        .clear (1'b0),
        .count (wb_cnt)
    );
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Testbench: tb_cache_mem_ctrl
// Purpose: Directed checks of cache_mem_ctrl with READ_LAT=2 against a small
//   behavioural RAM whose read data appears one clock after the address.
//   Optional statistics checks are compiled in with CACHE_CTRL_STATS_EN.
module tb_cache_mem_ctrl;
    import cache_pkg::*;

    localparam int AW  = 5;
    localparam int DW  = 5;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic          req;
    logic [AW-1:0] miss_addr;
    logic          wb_needed;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_block;
    logic          ack;
    logic [DW-1:0] refill_block;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_rdata;
    state_t        state_dbg;
`ifdef CACHE_CTRL_STATS_EN
    logic [1:0]    miss_cnt;
    logic [1:0]    wb_cnt;
`endif

    cache_mem_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .READ_LAT (LAT)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .STAT_W   (2)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .miss_addr    (miss_addr),
        .wb_needed    (wb_needed),
        .wb_addr      (wb_addr),
        .wb_block     (wb_block),
        .ack          (ack),
        .refill_block (refill_block),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wren     (mem_wren),
        .mem_rdata    (mem_rdata),
        .state_dbg    (state_dbg)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt)
`endif
    );

    // ---------------- RAM model ----------------
    // Address presented in cycle n, read data registered on edge n and
    // captured by the sequencer on edge n+1: READ_LAT = 2.
    logic [DW-1:0] ram [0:31];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clock) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (mem_wren)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- checking ----------------
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All drivers start and end at a falling edge.
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Per-request observations, cycle 1 = first cycle after the accepting edge.
    logic [AW-1:0] addr_at  [1:8];
    logic [DW-1:0] wdata_at [1:8];
    logic          busy_at  [1:8];
    int            ack_cycle;
    int            ack_count;
    int            wren_count;
    int            wren_first;
    logic [DW-1:0] blk;

    // Issue one request and watch 8 cycles. Inputs are scrambled in cycle 1
    // to show they are not re-sampled. hold keeps req high one cycle past ack.
    task automatic run_req(input logic [AW-1:0] ma, input logic wbn,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input logic hold);
        int drop_at;
        req        = 1'b1;
        miss_addr  = ma;
        wb_needed  = wbn;
        wb_addr    = wa;
        wb_block   = wd;
        ack_cycle  = 0;
        ack_count  = 0;
        wren_count = 0;
        wren_first = 0;
        blk        = '0;
        drop_at    = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            addr_at[c]  = mem_addr;
            wdata_at[c] = mem_wdata;
            busy_at[c]  = busy;
            if (mem_wren) begin
                wren_count++;
                if (wren_first == 0) wren_first = c;
            end
            if (c == 1) begin
                miss_addr = AW'($urandom_range(0, 31));
                wb_needed = 1'($urandom_range(0, 1));
                wb_addr   = AW'($urandom_range(0, 31));
                wb_block  = DW'($urandom_range(0, 31));
            end
            if (ack) begin
                ack_count++;
                if (ack_cycle == 0) begin
                    ack_cycle = c;
                    blk       = refill_block;
                    drop_at   = hold ? c + 1 : c;
                end
            end
            if (c == drop_at) req = 1'b0;
        end
        req = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic          wbn_tab [0:4];
    logic [AW-1:0] ma_tab  [0:4];

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req       = 1'b0;
        miss_addr = '0;
        wb_needed = 1'b0;
        wb_addr   = '0;
        wb_block  = '0;
        pl_en     = 1'b0;
        pl_addr   = '0;
        pl_data   = '0;

        // 1: reset values, then idle with no request
        @(negedge clock);
        @(negedge clock);
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_wren",  32'(mem_wren), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_refill", 32'(refill_block), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("idle_ack",  32'(ack), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_wren", 32'(mem_wren), 32'd0);
        end

        // 2: plain refill
        preload(5'h0A, 5'h13);
        run_req(5'h0A, 1'b0, 5'h00, 5'h00, 1'b0);
        check("rd_addr_c1", 32'(addr_at[1]), 32'h0A);
        check("rd_addr_c2", 32'(addr_at[2]), 32'h0A);
        check("rd_busy_c1", 32'(busy_at[1]), 32'd1);
        check("rd_ack_cyc", 32'(ack_cycle), 32'd3);
        check("rd_ack_cnt", 32'(ack_count), 32'd1);
        check("rd_block",   32'(blk), 32'h13);
        check("rd_no_wren", 32'(wren_count), 32'd0);
        check("rd_idle_addr", 32'(addr_at[4]), 32'd0);
        check("rd_idle_busy", 32'(busy_at[4]), 32'd0);

        // 3: write-back then refill
        preload(5'h14, 5'h0B);
        run_req(5'h14, 1'b1, 5'h04, 5'h1F, 1'b0);
        check("wb_wren_cyc", 32'(wren_first), 32'd1);
        check("wb_wren_cnt", 32'(wren_count), 32'd1);
        check("wb_addr_c1",  32'(addr_at[1]), 32'h04);
        check("wb_data_c1",  32'(wdata_at[1]), 32'h1F);
        check("wb_rd_addr",  32'(addr_at[2]), 32'h14);
        check("wb_ack_cyc",  32'(ack_cycle), 32'd4);
        check("wb_block",    32'(blk), 32'h0B);
        check("wb_ram",      32'(ram[5'h04]), 32'h1F);
        check("wb_wdata_hold", 32'(wdata_at[5]), 32'h1F);
        check("wb_idle_addr",  32'(addr_at[5]), 32'd0);

        // 4: write-back and refill of the same block
        preload(5'h07, 5'h02);
        run_req(5'h07, 1'b1, 5'h07, 5'h09, 1'b0);
        check("raw_ack_cyc", 32'(ack_cycle), 32'd4);
        check("raw_block",   32'(blk), 32'h09);

        // 5: asynchronous reset in the middle of a write-back
        preload(5'h11, 5'h05);
        req       = 1'b1;
        miss_addr = 5'h02;
        wb_needed = 1'b1;
        wb_addr   = 5'h11;
        wb_block  = 5'h1A;
        @(negedge clock);
        check("arst_wren_pre",  32'(mem_wren), 32'd1);
        check("arst_state_pre", 32'(state_dbg), 32'(WB));
        #2 reset = 1'b1;
        #1;
        check("arst_wren",  32'(mem_wren), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clock);
        req   = 1'b0;
        reset = 1'b0;
        ack_count = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (ack) ack_count++;
        end
        check("arst_no_ack", 32'(ack_count), 32'd0);
        check("arst_ram",    32'(ram[5'h11]), 32'h05);
`ifdef CACHE_CTRL_STATS_EN
        check("arst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("arst_wb_cnt",   32'(wb_cnt), 32'd0);
`endif

        // 6: req held through DONE, five requests, four with write-back
        wbn_tab = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        ma_tab  = '{5'h01, 5'h02, 5'h03, 5'h05, 5'h06};
        for (int i = 0; i < 5; i++) begin
            run_req(ma_tab[i], wbn_tab[i], 5'h18, 5'h0C, 1'b1);
            check("hold_ack_cnt", 32'(ack_count), 32'd1);
            check("hold_ack_cyc", 32'(ack_cycle), wbn_tab[i] ? 32'd4 : 32'd3);
        end
`ifdef CACHE_CTRL_STATS_EN
        check("sat_miss_cnt", 32'(miss_cnt), 32'd3);
        check("sat_wb_cnt",   32'(wb_cnt), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
